// File: rtl/col_driver.sv
// Column driver for a compute-in-memory array.
// Drives the bit-line pair of each column from flip-flops. MAC mode selects a
// single column from the address. CAM mode drives the search key onto the
// true lines and its complement onto the complement lines. Idle, or an
// unknown enable or mode, drives both lines low.
module col_driver #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             w_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] BL,
  output logic [WIDTH-1:0] BLB
);

  // One-hot decode of a column address.
  function automatic logic [WIDTH-1:0] col_onehot(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v    = {WIDTH{1'b0}};
    v[a] = 1'b1;
    return v;
  endfunction

  logic [WIDTH-1:0] bl_next_s;
  logic [WIDTH-1:0] blb_next_s;
  logic [WIDTH-1:0] bl_r;
  logic [WIDTH-1:0] blb_r;

  // Select the next line drive from enable and mode. Any non-0/1 pattern falls to idle.
  always_comb begin
    bl_next_s  = {WIDTH{1'b0}};
    blb_next_s = {WIDTH{1'b0}};
    case ({en, w_en})
      2'b11: begin
        bl_next_s  = col_onehot(addr);
        blb_next_s = ~col_onehot(addr);
      end
      2'b10: begin
        bl_next_s  = data;
        blb_next_s = ~data;
      end
      default: begin
        bl_next_s  = {WIDTH{1'b0}};
        blb_next_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Output registers. Reset clears both lines at once, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bl_r  <= {WIDTH{1'b0}};
      blb_r <= {WIDTH{1'b0}};
    end else begin
      bl_r  <= bl_next_s;
      blb_r <= blb_next_s;
    end
  end

  assign BL  = bl_r;
  assign BLB = blb_r;

endmodule

// File: tb/tb_col_driver.sv
// Scoreboard bench for col_driver: directed scenarios followed by random traffic.
module tb_col_driver;

  localparam int WIDTH = 8;
  localparam int AW    = 3;

  typedef struct {
    logic [WIDTH-1:0] bl;
    logic [WIDTH-1:0] blb;
    bit               enabled;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             w_en;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] BL;
  logic [WIDTH-1:0] BLB;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t last_exp = '{bl: 8'h00, blb: 8'h00, enabled: 1'b0};

  col_driver #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .w_en(w_en),
    .addr(addr), .data(data), .BL(BL), .BLB(BLB)
  );

  always #5 clk = ~clk;

  // Reference model: what the lines must carry for the given inputs.
  function automatic exp_t model(input logic e, input logic w,
                                 input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    exp_t r;
    r.enabled = 1'b0;
    r.bl  = 8'h00;
    r.blb = 8'h00;
    if (e === 1'b1 && w === 1'b1) begin
      r.enabled = 1'b1;
      r.bl  = 8'(1 << int'(a));
      r.blb = ~r.bl;
    end else if (e === 1'b1 && w === 1'b0) begin
      r.enabled = 1'b1;
      r.bl  = d;
      r.blb = ~d;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%02h, expected 0x%02h", name, $time, act, req);
    end
  endtask

  // Reset discards everything in flight.
  always @(negedge rst_n) begin
    exp_q.delete();
    last_exp = '{bl: 8'h00, blb: 8'h00, enabled: 1'b0};
  end

  // Each rising edge out of reset captures the expected next output.
  always @(posedge clk) begin
    if (rst_n === 1'b1) exp_q.push_back(model(en, w_en, addr, data));
  end

  // Monitor: compare the registered outputs mid-cycle.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      check("reset_bl", BL, 8'h00);
      check("reset_blb", BLB, 8'h00);
    end else begin
      if (exp_q.size() > 0) last_exp = exp_q.pop_front();
      check("bl", BL, last_exp.bl);
      check("blb", BLB, last_exp.blb);
      if (last_exp.enabled) check("exclusion", BL ^ BLB, 8'hFF);
    end
  end

  task automatic drive(input logic e, input logic w, input logic [AW-1:0] a,
                       input logic [WIDTH-1:0] d);
    @(posedge clk);
    #2;
    en = e; w_en = w; addr = a; data = d;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; w_en = 1'b1; addr = 3'd2; data = 8'h00;
    #1;
    check("async_reset_bl", BL, 8'h00);
    check("async_reset_blb", BLB, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1; en = 1'b0;
    drive(1'b0, 1'b1, 3'd2, 8'h00);
    drive(1'b0, 1'b1, 3'd2, 8'h00);
    // MAC select, data independence, address change
    drive(1'b1, 1'b1, 3'b010, 8'h00);
    drive(1'b1, 1'b1, 3'b010, 8'hFF);
    drive(1'b1, 1'b1, 3'b001, 8'hFF);
    // CAM key, address independence
    drive(1'b1, 1'b0, 3'b001, 8'hFF);
    drive(1'b1, 1'b0, 3'b001, 8'hAA);
    drive(1'b1, 1'b0, 3'b011, 8'hAA);
    drive(1'b1, 1'b0, 3'b011, 8'hAA);
    // Asynchronous clear between edges while BL=0xAA
    @(posedge clk);
    #3;
    check("pre_clear_bl", BL, 8'hAA);
    rst_n = 1'b0;
    #1;
    check("mid_clear_bl", BL, 8'h00);
    check("mid_clear_blb", BLB, 8'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    // Random traffic, including unknown enable/mode and occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      logic e;
      logic w;
      e = 1'($urandom);
      w = 1'($urandom);
      if ($urandom_range(0, 15) == 0) e = 1'bx;
      if ($urandom_range(0, 15) == 0) w = 1'bx;
      drive(e, w, AW'($urandom), WIDTH'($urandom));
      if ($urandom_range(0, 40) == 0) begin
        #4;
        rst_n = 1'b0;
        #1;
        check("rand_clear_bl", BL, 8'h00);
        check("rand_clear_blb", BLB, 8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/col_driver.md
COL_DRIVER -- requirements
Module: col_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of array columns (bit-line pairs).
REQ-002 The block SHALL have parameter AW, default 3, giving the column-address width (2^AW = WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: drive enable; 0 selects idle (no column driven).
REQ-006 The block SHALL have port w_en, input, 1 bit: mode select; 1 = MAC read mode, 0 = CAM search mode.
REQ-007 The block SHALL have port addr, input, AW bits: column address, used only in MAC mode.
REQ-008 The block SHALL have port data, input, WIDTH bits: search key, used only in CAM mode.
REQ-009 The block SHALL have port BL, output, WIDTH bits: registered true bit-line drive, one bit per column.
REQ-010 The block SHALL have port BLB, output, WIDTH bits: registered complement bit-line drive, one bit per column.

Function
REQ-011 BL and BLB SHALL be driven directly from flip-flops, with no combinational path from any input to any output.
REQ-012 Outputs SHALL reflect the inputs sampled at a rising clk edge one cycle later (latency 1).
REQ-013 Idle (en=0) SHALL load BL=0 and BLB=0 on every column.
REQ-014 MAC mode (en=1, w_en=1) SHALL load BL = one-hot decode of addr: bit[addr]=1, all others 0.
REQ-015 MAC mode SHALL load BLB = bitwise inverse of the BL value loaded in the same cycle.
REQ-016 In MAC mode, data SHALL have no effect on BL or BLB.
REQ-017 CAM mode (en=1, w_en=0) SHALL load BL = data.
REQ-018 CAM mode SHALL load BLB = ~data.
REQ-019 In CAM mode, addr SHALL have no effect on BL or BLB.
REQ-020 In any enabled mode, each column SHALL satisfy BL[i] != BLB[i], so no column ever has both lines driven high.
REQ-021 A mode switch on w_en SHALL take effect on the next rising edge, with no intermediate idle cycle.
REQ-022 Changes to addr or data SHALL take effect on the next rising edge, and outputs SHALL hold between edges.
REQ-023 Any unknown (X) value on w_en or en SHALL be treated as idle, loading 0/0.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously force BL=0 and BLB=0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL clear the outputs immediately, discarding the in-flight mode.
REQ-026 After rst_n deasserts, the first rising edge SHALL load the value selected by the current inputs.

Verification
REQ-027 Reset and idle: rst_n=0 with en=1, w_en=1, addr=2 SHALL give BL=0x00, BLB=0x00 with no clock edge; after release, en=0 SHALL keep BL=0x00, BLB=0x00.
REQ-028 MAC select: en=1, w_en=1, addr=3'b010, data=0x00 SHALL give BL=0x04, BLB=0xFB one cycle later; with data changed to 0xFF, outputs SHALL remain BL=0x04, BLB=0xFB.
REQ-029 MAC address change: addr=3'b001 SHALL give BL=0x02, BLB=0xFD after the next edge.
REQ-030 CAM key: w_en=0 with data=0xFF SHALL give BL=0xFF, BLB=0x00; then data=0xAA SHALL give BL=0xAA, BLB=0x55.
REQ-031 CAM address independence: with w_en=0, changing addr to 3'b011 SHALL leave BL=0xAA, BLB=0x55 unchanged.
REQ-032 Asynchronous clear: asserting rst_n=0 between clock edges while BL=0xAA SHALL give BL=0x00, BLB=0x00 immediately, and the complement-exclusion rule of REQ-020 SHALL be checked on every enabled cycle.
